// File: rtl/char_bbox_scan.sv
// ---------------------------------------------------------------------------
// char_bbox_scan
//
// Purpose:
//   Finds the bounding box of one licence-plate character in each video
//   frame. Inside a plate search window it tracks, row by row, how many
//   stroke pixels (i_th = 1) were seen and their horizontal extent. Rows
//   with enough strokes are "text rows". They grow a per-frame box. When
//   the frame's vertical-sync window closes, the box is checked against a
//   minimum size. It is then either committed to the outputs or reported
//   as a miss. Committed values stay stable for the whole next frame.
//
// Ports:
//   clk, rst_n               pixel clock, asynchronous active-low reset
//   i_hs, i_vs, i_de         video syncs (i_vs high = active frame,
//                            i_de high = active pixel)
//   i_x, i_y                 current pixel position (12 bit)
//   i_th                     binarised pixel, 1 = character stroke
//   plate_up/down/left/right search window, inclusive (12 bit each)
//   char_up/down/left/right  committed character box (12 bit each)
//   char_valid               one-cycle pulse when a new box is committed
//   char_miss                one-cycle pulse when a frame gives no box
//   char_found               level, last completed frame produced a box
// ---------------------------------------------------------------------------
module char_bbox_scan #(
    parameter int ROW_MIN = 2,
    parameter int MIN_W   = 20,
    parameter int MIN_H   = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_hs,
    input  logic        i_vs,
    input  logic        i_de,
    input  logic [11:0] i_x,
    input  logic [11:0] i_y,
    input  logic        i_th,
    input  logic [11:0] plate_up,
    input  logic [11:0] plate_down,
    input  logic [11:0] plate_left,
    input  logic [11:0] plate_right,
    output logic [11:0] char_up,
    output logic [11:0] char_down,
    output logic [11:0] char_left,
    output logic [11:0] char_right,
    output logic        char_valid,
    output logic        char_miss,
    output logic        char_found
);

    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        SCAN    = 2'd1,
        COMMIT  = 2'd2
    } scanState_t;

    scanState_t  r_state;

    // Horizontal sync carries no information the row logic needs, because
    // rows are delimited by i_de.
    logic        w_unusedHs;
    assign w_unusedHs = i_hs;

    // -----------------------------------------------------------------------
    // Sync edge detection
    // -----------------------------------------------------------------------
    logic        r_vsD;
    logic        r_deD;
    logic        r_rowClose;
    logic        w_vsRise;
    logic        w_vsFall;
    logic        w_deFall;

    assign w_vsRise = i_vs & ~r_vsD;
    assign w_vsFall = ~i_vs & r_vsD;
    assign w_deFall = ~i_de & r_deD;

    // r_vsD resets high. If reset is released in the middle of a frame,
    // the still-high i_vs is then not mistaken for a frame start, so the
    // partial frame is discarded. The row close is registered one cycle
    // behind the i_de falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsD      <= 1'b1;
            r_deD      <= 1'b0;
            r_rowClose <= 1'b0;
        end else begin
            r_vsD      <= i_vs;
            r_deD      <= i_de;
            r_rowClose <= w_deFall;
        end
    end

    // -----------------------------------------------------------------------
    // Search window, frozen for the whole frame at its start
    // -----------------------------------------------------------------------
    logic [11:0] r_winUp;
    logic [11:0] r_winDown;
    logic [11:0] r_winLeft;
    logic [11:0] r_winRight;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_winUp    <= 12'd0;
            r_winDown  <= 12'd0;
            r_winLeft  <= 12'd0;
            r_winRight <= 12'd0;
        end else if (w_vsRise) begin
            r_winUp    <= plate_up;
            r_winDown  <= plate_down;
            r_winLeft  <= plate_left;
            r_winRight <= plate_right;
        end
    end

    logic        w_inWin;
    logic        w_strokePix;

    assign w_inWin = i_de
                     && (i_x >= r_winLeft) && (i_x <= r_winRight)
                     && (i_y >= r_winUp)   && (i_y <= r_winDown);
    assign w_strokePix = w_inWin & i_th;

    // -----------------------------------------------------------------------
    // Per-row accumulators
    // -----------------------------------------------------------------------
    logic [11:0] r_rowCnt;
    logic [11:0] r_rowMinX;
    logic [11:0] r_rowMaxX;
    logic [11:0] r_rowY;

    // On a row-close cycle, updates start from the cleared values. A stroke
    // pixel arriving on that same cycle then opens the next row at count 1
    // instead of being dropped.
    logic [11:0] w_baseCnt;
    logic [11:0] w_baseMinX;
    logic [11:0] w_baseMaxX;
    logic [11:0] w_cntInc;

    assign w_baseCnt  = r_rowClose ? 12'd0   : r_rowCnt;
    assign w_baseMinX = r_rowClose ? 12'hFFF : r_rowMinX;
    assign w_baseMaxX = r_rowClose ? 12'd0   : r_rowMaxX;
    assign w_cntInc   = (w_baseCnt == 12'hFFF) ? 12'hFFF : w_baseCnt + 12'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rowCnt  <= 12'd0;
            r_rowMinX <= 12'hFFF;
            r_rowMaxX <= 12'd0;
            r_rowY    <= 12'd0;
        end else begin
            if (w_strokePix) begin
                r_rowCnt  <= w_cntInc;
                r_rowMinX <= (i_x < w_baseMinX) ? i_x : w_baseMinX;
                r_rowMaxX <= (i_x > w_baseMaxX) ? i_x : w_baseMaxX;
            end else begin
                r_rowCnt  <= w_baseCnt;
                r_rowMinX <= w_baseMinX;
                r_rowMaxX <= w_baseMaxX;
            end
            if (i_de) begin
                r_rowY <= i_y;
            end else if (r_rowClose) begin
                r_rowY <= 12'd0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Frame accumulators
    // -----------------------------------------------------------------------
    logic [11:0] r_fUp;
    logic [11:0] r_fDown;
    logic [11:0] r_fLeft;
    logic [11:0] r_fRight;
    logic        r_fAny;

    // The "next" frame values already include a row closing on this cycle.
    // COMMIT evaluates these values, so a last row whose i_de falls
    // together with i_vs is still counted.
    logic        w_rowText;
    logic [11:0] w_fUpN;
    logic [11:0] w_fDownN;
    logic [11:0] w_fLeftN;
    logic [11:0] w_fRightN;
    logic        w_fAnyN;

    assign w_rowText = r_rowClose && (r_rowCnt >= 12'(ROW_MIN));
    assign w_fUpN    = (w_rowText && !r_fAny) ? r_rowY : r_fUp;
    assign w_fDownN  = w_rowText ? r_rowY : r_fDown;
    assign w_fLeftN  = (w_rowText && (r_rowMinX < r_fLeft))  ? r_rowMinX : r_fLeft;
    assign w_fRightN = (w_rowText && (r_rowMaxX > r_fRight)) ? r_rowMaxX : r_fRight;
    assign w_fAnyN   = r_fAny | w_rowText;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fUp    <= 12'd0;
            r_fDown  <= 12'd0;
            r_fLeft  <= 12'hFFF;
            r_fRight <= 12'd0;
            r_fAny   <= 1'b0;
        end else if (w_vsRise) begin
            r_fUp    <= 12'd0;
            r_fDown  <= 12'd0;
            r_fLeft  <= 12'hFFF;
            r_fRight <= 12'd0;
            r_fAny   <= 1'b0;
        end else begin
            r_fUp    <= w_fUpN;
            r_fDown  <= w_fDownN;
            r_fLeft  <= w_fLeftN;
            r_fRight <= w_fRightN;
            r_fAny   <= w_fAnyN;
        end
    end

    // -----------------------------------------------------------------------
    // Acceptance test
    // -----------------------------------------------------------------------
    // The differences are only meaningful when w_fAnyN is set, because only
    // then is down >= up and right >= left. The AND keeps the wrapped
    // values of an empty frame from being used.
    logic [11:0] w_fHeight;
    logic [11:0] w_fWidth;
    logic        w_accept;

    assign w_fHeight = w_fDownN - w_fUpN;
    assign w_fWidth  = w_fRightN - w_fLeftN;
    assign w_accept  = w_fAnyN
                       && (w_fHeight >= 12'(MIN_H))
                       && (w_fWidth  >= 12'(MIN_W));

    // -----------------------------------------------------------------------
    // Frame state machine with registered outputs
    // -----------------------------------------------------------------------
    // WAIT_VS waits for a frame start. SCAN lets the accumulators run.
    // COMMIT publishes or rejects the box in a single cycle. The pulses
    // default low every cycle, so each lasts exactly one clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= WAIT_VS;
            char_up    <= 12'd0;
            char_down  <= 12'd0;
            char_left  <= 12'd0;
            char_right <= 12'd0;
            char_valid <= 1'b0;
            char_miss  <= 1'b0;
            char_found <= 1'b0;
        end else begin
            char_valid <= 1'b0;
            char_miss  <= 1'b0;
            unique case (r_state)
                WAIT_VS: begin
                    if (w_vsRise) begin
                        r_state <= SCAN;
                    end
                end
                SCAN: begin
                    if (w_vsFall) begin
                        r_state <= COMMIT;
                    end
                end
                COMMIT: begin
                    if (w_accept) begin
                        char_up    <= w_fUpN;
                        char_down  <= w_fDownN;
                        char_left  <= w_fLeftN;
                        char_right <= w_fRightN;
                        char_valid <= 1'b1;
                        char_found <= 1'b1;
                    end else begin
                        char_miss  <= 1'b1;
                        char_found <= 1'b0;
                    end
                    r_state <= WAIT_VS;
                end
                default: begin
                    r_state <= WAIT_VS;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_char_bbox_scan.sv
// ---------------------------------------------------------------------------
// tb_char_bbox_scan
//
// Drives sparse video frames into char_bbox_scan. Each active line carries
// only a short list of x positions, which keeps frames small. The bench
// checks the committed box, the pulses and the found level against values
// worked out by hand for each stroke pattern.
// ---------------------------------------------------------------------------
module tb_char_bbox_scan;

    logic        clk;
    logic        rst_n;
    logic        i_hs;
    logic        i_vs;
    logic        i_de;
    logic [11:0] i_x;
    logic [11:0] i_y;
    logic        i_th;
    logic [11:0] plate_up;
    logic [11:0] plate_down;
    logic [11:0] plate_left;
    logic [11:0] plate_right;
    logic [11:0] char_up;
    logic [11:0] char_down;
    logic [11:0] char_left;
    logic [11:0] char_right;
    logic        char_valid;
    logic        char_miss;
    logic        char_found;

    int checkCount = 0;
    int passCount  = 0;

    // Pixel columns visited on every active line. The list covers both
    // sides of each window edge (99/100, 300/301) and two far-outside
    // columns.
    int xList[11] = '{50, 99, 100, 150, 160, 175, 202, 203, 300, 301, 350};

    char_bbox_scan #(
        .ROW_MIN (2),
        .MIN_W   (20),
        .MIN_H   (30)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_hs        (i_hs),
        .i_vs        (i_vs),
        .i_de        (i_de),
        .i_x         (i_x),
        .i_y         (i_y),
        .i_th        (i_th),
        .plate_up    (plate_up),
        .plate_down  (plate_down),
        .plate_left  (plate_left),
        .plate_right (plate_right),
        .char_up     (char_up),
        .char_down   (char_down),
        .char_left   (char_left),
        .char_right  (char_right),
        .char_valid  (char_valid),
        .char_miss   (char_miss),
        .char_found  (char_found)
    );

    // Free-running pixel clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something stalls the stimulus
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one pixel clock on the falling edge
    task automatic applyStimulus(input logic vs, input logic de, input int x,
                                 input int y, input logic th);
        @(negedge clk);
        i_vs = vs;
        i_de = de;
        i_hs = ~de;
        i_x  = 12'(x);
        i_y  = 12'(y);
        i_th = th;
    endtask

    // Stroke patterns, one per test frame
    function automatic logic stroke(input int pat, input int x, input int y);
        logic nominal;
        nominal = (y >= 220) && (y <= 294) && ((x == 150) || (x == 175) || (x == 203));
        case (pat)
            0: return nominal;
            1: return nominal || ((x == 175) && ((y == 210) || (y == 299)));
            2: return (y >= 220) && (y <= 230) && ((x == 150) || (x == 160));
            3: return (y >= 230) && (y <= 280) &&
                      ((x == 50) || (x == 99) || (x == 160) || (x == 202) ||
                       (x == 301) || (x == 350));
            4: return (y >= 199) && (y <= 301) && ((x == 100) || (x == 300));
            default: return 1'b0;
        endcase
    endfunction

    // One frame. The last line drops i_de and i_vs on the same clock.
    // A nonzero resetY pulses rst_n just before that line.
    task automatic runFrame(input int pat, input int yFirst, input int yLast,
                            input int resetY);
        repeat (4) applyStimulus(1'b1, 1'b0, 0, 0, 1'b0);
        for (int y = yFirst; y <= yLast; y++) begin
            if (y == resetY) begin
                @(negedge clk);
                rst_n = 1'b0;
                #1;
                checkOutput("rst_up",    int'(char_up),    0);
                checkOutput("rst_down",  int'(char_down),  0);
                checkOutput("rst_left",  int'(char_left),  0);
                checkOutput("rst_right", int'(char_right), 0);
                checkOutput("rst_found", int'(char_found), 0);
                checkOutput("rst_valid", int'(char_valid), 0);
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
            end
            for (int i = 0; i < 11; i++) begin
                applyStimulus(1'b1, 1'b1, xList[i], y, stroke(pat, xList[i], y));
            end
            if (y == yLast) begin
                applyStimulus(1'b0, 1'b0, 0, y, 1'b0);
            end else begin
                repeat (3) applyStimulus(1'b1, 1'b0, 0, y, 1'b0);
            end
        end
    endtask

    // Count commit pulses over a bounded window after the frame ends, then
    // check the box and the found level.
    task automatic checkFrame(input string tag, input int expValid, input int expMiss,
                              input int expUp, input int expDown, input int expLeft,
                              input int expRight, input int expFound);
        int nValid;
        int nMiss;
        nValid = 0;
        nMiss  = 0;
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);
            if (char_valid) nValid++;
            if (char_miss)  nMiss++;
        end
        checkOutput({tag, "_validPulses"}, nValid, expValid);
        checkOutput({tag, "_missPulses"},  nMiss,  expMiss);
        checkOutput({tag, "_up"},    int'(char_up),    expUp);
        checkOutput({tag, "_down"},  int'(char_down),  expDown);
        checkOutput({tag, "_left"},  int'(char_left),  expLeft);
        checkOutput({tag, "_right"}, int'(char_right), expRight);
        checkOutput({tag, "_found"}, int'(char_found), expFound);
    endtask

    initial begin
        rst_n       = 1'b0;
        i_vs        = 1'b0;
        i_de        = 1'b0;
        i_hs        = 1'b1;
        i_x         = 12'd0;
        i_y         = 12'd0;
        i_th        = 1'b0;
        plate_up    = 12'd200;
        plate_down  = 12'd300;
        plate_left  = 12'd100;
        plate_right = 12'd300;
        repeat (3) @(negedge clk);

        checkOutput("reset_up",    int'(char_up),    0);
        checkOutput("reset_right", int'(char_right), 0);
        checkOutput("reset_valid", int'(char_valid), 0);
        checkOutput("reset_miss",  int'(char_miss),  0);
        checkOutput("reset_found", int'(char_found), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("[TB] nominal box");
        runFrame(0, 205, 300, 0);
        checkFrame("nominal", 1, 0, 220, 294, 150, 203, 1);

        $display("[TB] single-pixel rows ignored");
        runFrame(1, 205, 300, 0);
        checkFrame("rowmin", 1, 0, 220, 294, 150, 203, 1);

        $display("[TB] box too small");
        runFrame(2, 205, 300, 0);
        checkFrame("small", 0, 1, 220, 294, 150, 203, 0);

        $display("[TB] strokes outside window");
        runFrame(3, 205, 300, 0);
        checkFrame("outwin", 1, 0, 230, 280, 160, 202, 1);

        $display("[TB] strokes on inclusive window edges");
        runFrame(4, 195, 305, 0);
        checkFrame("edges", 1, 0, 200, 300, 100, 300, 1);

        $display("[TB] last text row on frame end");
        runFrame(0, 205, 294, 0);
        checkFrame("lastrow", 1, 0, 220, 294, 150, 203, 1);

        $display("[TB] reset in mid frame");
        runFrame(0, 205, 300, 251);
        checkFrame("partial", 0, 0, 0, 0, 0, 0, 0);
        runFrame(0, 205, 300, 0);
        checkFrame("afterrst", 1, 0, 220, 294, 150, 203, 1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/char_bbox_scan.md
# char_bbox_scan

Finds the bounding box of one licence-plate character in each video frame. It builds row and column extents of binarised pixels inside a plate window. The block sits directly upstream of the 3×3 digit feature scanner and drives that scanner's `char_up`/`char_down`/`char_left`/`char_right` inputs. Results are committed once per frame, shortly after the frame's vertical-sync window closes. They then stay stable for the whole next frame.

## Interface
Parameters:
- `ROW_MIN`, 2: minimum thresholded pixels in a row for that row to count as a text row.
- `MIN_W`, 20: minimum accepted box width (`right-left`).
- `MIN_H`, 30: minimum accepted box height (`down-up`).

Ports:
- `clk`  in  1  pixel clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `i_hs`, `i_vs`, `i_de`  in  1 each  video syncs; `i_vs` is high during the active frame, `i_de` is high on active pixels.
- `i_x`, `i_y`  in  12 each  current pixel position.
- `i_th`  in  1  binarised pixel; 1 = character stroke.
- `plate_up`, `plate_down`, `plate_left`, `plate_right`  in  12 each  search window, inclusive.
- `char_up`, `char_down`, `char_left`, `char_right`  out  12 each  committed box; reset value 0.
- `char_valid`  out  1  one-cycle pulse when a new box is committed; reset value 0.
- `char_miss`  out  1  one-cycle pulse when a frame yields no acceptable box; reset value 0.
- `char_found`  out  1  level: the last completed frame produced a box; reset value 0.

## Operation
- **State machine:** three states.
  - `WAIT_VS` is entered on reset. It moves to `SCAN` on a rising edge of `i_vs`, so the partial frame in progress at reset is discarded.
  - `SCAN` moves to `COMMIT` on a falling edge of `i_vs`.
  - `COMMIT` lasts one cycle, then returns to `WAIT_VS`.
- **Window latch:** at the `i_vs` rising edge the block latches `plate_*` into internal registers. Those registers are used for the whole frame.
- **In-window pixel:** `i_de` is 1 and `i_x` and `i_y` both lie within the latched window, bounds inclusive.
- **Per-row accumulators** (cleared at each row close):
  - `row_cnt`: 12 bits, saturating; incremented on each in-window pixel with `i_th`=1.
  - `row_minx` / `row_maxx`: minimum and maximum `i_x` among those pixels.
  - `row_y`: the `i_y` captured while `i_de` is high.
- **Row close:** a falling edge of `i_de`, registered. If `row_cnt >= ROW_MIN` the row is a text row:
  - On the first text row of the frame, `f_up` is set to `row_y`.
  - On every text row, `f_down` is set to `row_y`.
  - `f_left` is updated to `min(f_left, row_minx)` and `f_right` to `max(f_right, row_maxx)`.
  - `f_any` is set to 1.
- **Frame accumulators:** cleared at the `i_vs` rising edge. `f_left` clears to 0xFFF; `f_right`, `f_up`, `f_down` and `f_any` clear to 0.
- **COMMIT:** the box is accepted if `f_any`=1, `f_down-f_up >= MIN_H` and `f_right-f_left >= MIN_W`.
  - Accepted: load `char_*` from `f_*`, pulse `char_valid`, set `char_found`=1.
  - Not accepted: hold `char_*`, pulse `char_miss`, clear `char_found`.
- **Arithmetic:** all comparisons are unsigned 12-bit. Subtractions are only evaluated when `f_any`=1, which guarantees down ≥ up and right ≥ left.

## Timing
- **Latency:** `char_*`, `char_valid` and `char_miss` change 2 clocks after the first clock on which `i_vs` is sampled low:
  - edge-detect cycle → `COMMIT`;
  - the register update is visible on the following cycle.
- **Row close:** `row_cnt` is evaluated 1 clock after `i_de` is first sampled low. The per-row accumulators clear in that same cycle.
- **Simultaneous falling edges:** if `i_de` and `i_vs` fall on the same cycle, the row close is applied before `COMMIT` evaluates. The last row is therefore included.
- **Pixel and row close on the same cycle:** a new in-window pixel arriving on the same cycle as a row close starts the next row's accumulators at count 1. It is not lost.
- **Stability:** `char_*` are stable from commit until the next commit, covering the entire following frame, including downstream sample point (450,250).
- **Reset mid-frame:** all outputs return to 0 immediately (asynchronously). Nothing is committed until a full `i_vs` high period has been observed.
- **Missing rising edge:** if `i_vs` never rises, the state stays in `WAIT_VS` and the outputs hold.

## Test plan
- **Nominal box:** window (100..300, 200..300); strokes in x 150..203, y 220..294, 3 px per row. → After `i_vs` falls: `char_up`=220, `char_down`=294, `char_left`=150, `char_right`=203, `char_valid` high for 1 cycle, `char_found`=1.
- **ROW_MIN filtering:** rows with a single stroke pixel at y 210 and y 299; otherwise same as the nominal box. → Those rows are ignored; box unchanged (220/294/150/203).
- **Too small:** strokes only in x 150..160, y 220..230. → `char_miss` pulses; `char_*` hold the previous frame's values; `char_found`=0.
- **Out-of-window strokes:** stroke pixels at x 50 and x 350 alongside a valid character. → Excluded; `char_left`/`char_right` reflect in-window pixels only.
- **Last row on the frame boundary:** last text row at y 294, with `i_de` and `i_vs` falling on the same clock. → `char_down`=294.
- **Reset mid-frame:** `rst_n` low mid-`SCAN`, released, then 1 complete frame. → Outputs 0 during and after reset; the first commit happens only after the complete frame, with correct values.
